// File: rtl/hit_resolver_pkg.sv
// Shared definitions for the hit resolver and the player-side logic that
// drives its active/pull inputs.
package hit_resolver_pkg;

  // Hit type code meaning "no hit".
  localparam int HIT_NONE = 0;

  // Field slot of each coordinate inside a packed box; x1 occupies the LSBs.
  localparam int BOX_X1     = 0;
  localparam int BOX_X2     = 1;
  localparam int BOX_Y1     = 2;
  localparam int BOX_Y2     = 3;
  localparam int BOX_FIELDS = 4;

  // Per-attack player state, shared so the player FSMs and the active/pull
  // decode agree on one encoding.
  typedef enum logic [1:0] {
    PST_IDLE    = 2'd0,
    PST_PULL    = 2'd1,
    PST_END     = 2'd2,
    PST_RECOVER = 2'd3
  } player_state_e;

  // A box is hitting only in the END phase of its attack.
  function automatic logic state_is_active(input player_state_e s);
    return (s == PST_END);
  endfunction

  // A box is extended (hittable, not hitting) during PULL.
  function automatic logic state_is_pull(input player_state_e s);
    return (s == PST_PULL);
  endfunction

endpackage

// File: rtl/hit_resolver_box_overlap.sv
// Inclusive axis-aligned overlap test between two packed boxes. An inverted
// box (x1>x2 or y1>y2) is empty and never overlaps.
module box_overlap
  import hit_resolver_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic [BOX_FIELDS*COORD_W-1:0] box_a_i,
  input  logic [BOX_FIELDS*COORD_W-1:0] box_b_i,
  output logic                          overlap_o
);

  logic [COORD_W-1:0] ax1, ax2, ay1, ay2;
  logic [COORD_W-1:0] bx1, bx2, by1, by2;
  logic               a_empty, b_empty;

  assign ax1 = box_a_i[BOX_X1*COORD_W +: COORD_W];
  assign ax2 = box_a_i[BOX_X2*COORD_W +: COORD_W];
  assign ay1 = box_a_i[BOX_Y1*COORD_W +: COORD_W];
  assign ay2 = box_a_i[BOX_Y2*COORD_W +: COORD_W];
  assign bx1 = box_b_i[BOX_X1*COORD_W +: COORD_W];
  assign bx2 = box_b_i[BOX_X2*COORD_W +: COORD_W];
  assign by1 = box_b_i[BOX_Y1*COORD_W +: COORD_W];
  assign by2 = box_b_i[BOX_Y2*COORD_W +: COORD_W];

  assign a_empty = (ax1 > ax2) || (ay1 > ay2);
  assign b_empty = (bx1 > bx2) || (by1 > by2);

  assign overlap_o = !a_empty && !b_empty &&
                     (ax1 <= bx2) && (bx1 <= ax2) &&
                     (ay1 <= by2) && (by1 <= ay2);

endmodule

// File: rtl/hit_resolver.sv
// Per-frame player-vs-player hit resolution with one-hit-per-attack latching,
// trade detection and a hitstop freeze counter.
module hit_resolver
  import hit_resolver_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int N_ATK       = 2,
  parameter int TYPE_W      = 2,
  parameter int HITSTOP_LEN = 8,
  parameter int CNT_W       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic [4*COORD_W-1:0]          p1_hurt_box,
  input  logic [N_ATK*4*COORD_W-1:0]    p1_atk_boxes,
  input  logic [N_ATK-1:0]              p1_atk_active,
  input  logic [N_ATK-1:0]              p1_atk_pull,
  input  logic [4*COORD_W-1:0]          p2_hurt_box,
  input  logic [N_ATK*4*COORD_W-1:0]    p2_atk_boxes,
  input  logic [N_ATK-1:0]              p2_atk_active,
  input  logic [N_ATK-1:0]              p2_atk_pull,
  output logic                          p1_hit,
  output logic [TYPE_W-1:0]             p1_hit_type,
  output logic                          p2_hit,
  output logic [TYPE_W-1:0]             p2_hit_type,
  output logic                          trade,
  output logic                          hitstop
);

  localparam int BW = BOX_FIELDS * COORD_W;
  localparam int NT = N_ATK + 1;  // target slots: hurt box + every limb

  // ovl_12[k*NT+t]: P1 attack box k overlaps P2 target t (t=0 is hurt box).
  logic [N_ATK*NT-1:0] ovl_12, ovl_21;

  for (genvar k = 0; k < N_ATK; k++) begin : g_atk
    for (genvar t = 0; t < NT; t++) begin : g_tgt
      logic [BW-1:0] tgt_p1, tgt_p2;
      if (t == 0) begin : g_hurt
        assign tgt_p1 = p1_hurt_box;
        assign tgt_p2 = p2_hurt_box;
      end else begin : g_limb
        assign tgt_p1 = p1_atk_boxes[(t-1)*BW +: BW];
        assign tgt_p2 = p2_atk_boxes[(t-1)*BW +: BW];
      end
      box_overlap #(.COORD_W(COORD_W)) u_p1_on_p2 (
        .box_a_i  (p1_atk_boxes[k*BW +: BW]),
        .box_b_i  (tgt_p2),
        .overlap_o(ovl_12[k*NT+t])
      );
      box_overlap #(.COORD_W(COORD_W)) u_p2_on_p1 (
        .box_a_i  (p2_atk_boxes[k*BW +: BW]),
        .box_b_i  (tgt_p1),
        .overlap_o(ovl_21[k*NT+t])
      );
    end
  end

  logic [N_ATK-1:0]  cons1_q, cons1_d, cons2_q, cons2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d, trade_q, trade_d;
  logic [TYPE_W-1:0] p1_type_q, p1_type_d, p2_type_q, p2_type_d;

  logic              eval;
  logic [NT-1:0]     tgt_en1, tgt_en2;
  logic [N_ATK-1:0]  land12, land21, sel1, sel2;
  logic              hit_on_p1, hit_on_p2;
  logic [TYPE_W-1:0] code_on_p1, code_on_p2;

  assign eval    = frame_tick && (cnt_q == '0);
  assign tgt_en1 = {p1_atk_active | p1_atk_pull, 1'b1};
  assign tgt_en2 = {p2_atk_active | p2_atk_pull, 1'b1};

  // Find landing candidates in each direction; lowest landing box wins the type.
  always_comb begin
    land12     = '0;
    land21     = '0;
    sel1       = '0;
    sel2       = '0;
    hit_on_p2  = 1'b0;
    hit_on_p1  = 1'b0;
    code_on_p2 = TYPE_W'(HIT_NONE);
    code_on_p1 = TYPE_W'(HIT_NONE);
    for (int k = 0; k < N_ATK; k++) begin
      land12[k] = p1_atk_active[k] && !cons1_q[k] && |(ovl_12[k*NT +: NT] & tgt_en2);
      land21[k] = p2_atk_active[k] && !cons2_q[k] && |(ovl_21[k*NT +: NT] & tgt_en1);
      if (land12[k] && !hit_on_p2) begin
        hit_on_p2  = 1'b1;
        code_on_p2 = TYPE_W'(k + 1);
        sel1[k]    = 1'b1;
      end
      if (land21[k] && !hit_on_p1) begin
        hit_on_p1  = 1'b1;
        code_on_p1 = TYPE_W'(k + 1);
        sel2[k]    = 1'b1;
      end
    end
  end

  // Next state: pulses, held types, consumed latches and hitstop counter.
  always_comb begin
    p1_hit_d  = 1'b0;
    p2_hit_d  = 1'b0;
    trade_d   = 1'b0;
    p1_type_d = p1_type_q;
    p2_type_d = p2_type_q;
    cnt_d     = cnt_q;
    cons1_d   = cons1_q;
    cons2_d   = cons2_q;
    if (eval) begin
      p1_hit_d  = hit_on_p1;
      p2_hit_d  = hit_on_p2;
      trade_d   = hit_on_p1 && hit_on_p2;
      p1_type_d = code_on_p1;
      p2_type_d = code_on_p2;
      cons1_d   = cons1_q | sel1;
      cons2_d   = cons2_q | sel2;
      if (hit_on_p1 || hit_on_p2) cnt_d = CNT_W'(HITSTOP_LEN);
    end else if (frame_tick) begin
      cnt_d = cnt_q - 1'b1;  // eval is low here only because cnt_q is nonzero
    end
    // A retracted attack re-arms its box, even while frozen.
    cons1_d = cons1_d & (p1_atk_active | p1_atk_pull);
    cons2_d = cons2_d & (p2_atk_active | p2_atk_pull);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_hit_q  <= 1'b0;
      p2_hit_q  <= 1'b0;
      trade_q   <= 1'b0;
      p1_type_q <= '0;
      p2_type_q <= '0;
      cnt_q     <= '0;
      cons1_q   <= '0;
      cons2_q   <= '0;
    end else begin
      p1_hit_q  <= p1_hit_d;
      p2_hit_q  <= p2_hit_d;
      trade_q   <= trade_d;
      p1_type_q <= p1_type_d;
      p2_type_q <= p2_type_d;
      cnt_q     <= cnt_d;
      cons1_q   <= cons1_d;
      cons2_q   <= cons2_d;
    end
  end

  assign p1_hit      = p1_hit_q;
  assign p2_hit      = p2_hit_q;
  assign trade       = trade_q;
  assign p1_hit_type = p1_type_q;
  assign p2_hit_type = p2_type_q;
  assign hitstop     = (cnt_q != '0);

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver with hand-computed expectations.
module tb_hit_resolver;

  localparam int CW = 10;
  localparam int NA = 2;
  localparam int TW = 2;
  localparam int HL = 8;
  localparam int CN = 4;
  localparam int BW = 4 * CW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_tick;
  logic [BW-1:0]    p1_hurt_box, p2_hurt_box;
  logic [NA*BW-1:0] p1_atk_boxes, p2_atk_boxes;
  logic [NA-1:0]    p1_atk_active, p1_atk_pull, p2_atk_active, p2_atk_pull;
  logic             p1_hit, p2_hit, trade, hitstop;
  logic [TW-1:0]    p1_hit_type, p2_hit_type;

  int n_chk  = 0;
  int n_fail = 0;
  int hits;

  hit_resolver #(
    .COORD_W(CW), .N_ATK(NA), .TYPE_W(TW), .HITSTOP_LEN(HL), .CNT_W(CN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .p1_hurt_box  (p1_hurt_box),
    .p1_atk_boxes (p1_atk_boxes),
    .p1_atk_active(p1_atk_active),
    .p1_atk_pull  (p1_atk_pull),
    .p2_hurt_box  (p2_hurt_box),
    .p2_atk_boxes (p2_atk_boxes),
    .p2_atk_active(p2_atk_active),
    .p2_atk_pull  (p2_atk_pull),
    .p1_hit       (p1_hit),
    .p1_hit_type  (p1_hit_type),
    .p2_hit       (p2_hit),
    .p2_hit_type  (p2_hit_type),
    .trade        (trade),
    .hitstop      (hitstop)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] mkbox(input int x1, input int x2, input int y1, input int y2);
    return {CW'(y2), CW'(y1), CW'(x2), CW'(x1)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame strobe; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  // Retract everything and run out any hitstop plus one clean evaluation.
  task automatic drain();
    @(negedge clk);
    p1_atk_active = '0; p1_atk_pull = '0;
    p2_atk_active = '0; p2_atk_pull = '0;
    repeat (HL + 1) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] far;
    far = mkbox(900, 910, 900, 910);
    rst_n = 1'b0; frame_tick = 1'b0;
    p1_atk_active = '0; p1_atk_pull = '0; p2_atk_active = '0; p2_atk_pull = '0;
    p1_hurt_box = mkbox(0, 20, 0, 20);
    p2_hurt_box = mkbox(130, 170, 0, 100);
    p1_atk_boxes = {far, mkbox(100, 140, 50, 60)};
    p2_atk_boxes = {far, far};
    #12;
    check("rst_hitstop", 32'(hitstop), 0);
    check("rst_p2_hit", 32'(p2_hit), 0);
    check("rst_types", 32'({p1_hit_type, p2_hit_type}), 0);
    @(negedge clk) rst_n = 1'b1;

    // Basic hit and hitstop length
    p1_atk_active = 2'b01;
    tick();
    check("hit_p2", 32'(p2_hit), 1);
    check("hit_p2_type", 32'(p2_hit_type), 1);
    check("hit_p1", 32'(p1_hit), 0);
    check("hit_trade", 32'(trade), 0);
    check("hit_hitstop", 32'(hitstop), 1);
    hits = 1;
    @(posedge clk); #1;
    check("pulse_width", 32'(p2_hit), 0);
    check("type_held", 32'(p2_hit_type), 1);
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (p2_hit) hits++;
      if (i == 8)  check("hitstop_last", 32'(hitstop), 1);
      if (i == 9)  check("hitstop_done", 32'(hitstop), 0);
      if (i == 10) check("type_cleared", 32'(p2_hit_type), 0);
    end
    check("single_hit_cnt", 32'(hits), 1);

    // Retract one clk, re-activate: new hit
    @(negedge clk) p1_atk_active = 2'b00;
    @(negedge clk) p1_atk_active = 2'b01;
    tick();
    check("rehit", 32'(p2_hit), 1);
    // Re-arm during hitstop; 1->0 tick must not evaluate
    @(negedge clk) p1_atk_active = 2'b00;
    @(negedge clk) p1_atk_active = 2'b01;
    repeat (HL - 1) tick();
    tick();
    check("zero_tick_noeval", 32'(p2_hit), 0);
    check("zero_tick_hitstop", 32'(hitstop), 0);
    tick();
    check("after_zero_eval", 32'(p2_hit), 1);
    repeat (3) tick();
    check("mid_hitstop", 32'(hitstop), 1);

    // Asynchronous reset mid-hitstop
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_hitstop", 32'(hitstop), 0);
    check("arst_type", 32'(p2_hit_type), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_hit", 32'(p2_hit), 1);
    check("post_rst_type", 32'(p2_hit_type), 1);
    drain();
    check("drain_type", 32'(p2_hit_type), 0);

    // Trade
    @(negedge clk);
    p1_hurt_box = mkbox(300, 340, 0, 100);
    p1_atk_boxes = {mkbox(340, 380, 40, 60), far};
    p2_hurt_box = mkbox(370, 410, 0, 100);
    p2_atk_boxes = {far, mkbox(310, 345, 40, 60)};
    p1_atk_active = 2'b10; p2_atk_active = 2'b01;
    tick();
    check("trade_p1", 32'(p1_hit), 1);
    check("trade_p2", 32'(p2_hit), 1);
    check("trade", 32'(trade), 1);
    check("trade_p1_type", 32'(p1_hit_type), 1);
    check("trade_p2_type", 32'(p2_hit_type), 2);
    @(posedge clk); #1;
    check("trade_pulse", 32'(trade), 0);
    drain();

    // Pull-only never hits; pulled limb is hittable
    @(negedge clk);
    p1_hurt_box = mkbox(180, 215, 0, 100);
    p1_atk_boxes = {far, mkbox(225, 250, 45, 48)};
    p2_hurt_box = mkbox(400, 440, 0, 100);
    p2_atk_boxes = {far, mkbox(200, 230, 40, 50)};
    p2_atk_pull = 2'b01;
    tick();
    check("pull_nohit_p1", 32'(p1_hit), 0);
    check("pull_nohit_hs", 32'(hitstop), 0);
    @(negedge clk) p1_atk_active = 2'b01;
    tick();
    check("pull_limb_hit", 32'(p2_hit), 1);
    check("pull_limb_p1", 32'(p1_hit), 0);
    drain();

    // Edges: touching at x=140, just past, and an inverted box
    @(negedge clk);
    p1_hurt_box = mkbox(0, 20, 0, 20);
    p1_atk_boxes = {far, mkbox(100, 140, 50, 60)};
    p2_hurt_box = mkbox(140, 170, 0, 100);
    p2_atk_boxes = {far, far};
    p1_atk_active = 2'b01;
    tick();
    check("edge_touch", 32'(p2_hit), 1);
    drain();
    @(negedge clk);
    p1_atk_boxes = {far, mkbox(171, 180, 50, 60)};
    p1_atk_active = 2'b01;
    tick();
    check("edge_miss", 32'(p2_hit), 0);
    @(negedge clk);
    p1_atk_boxes = {mkbox(150, 149, 50, 60), far};
    p2_hurt_box = mkbox(100, 200, 0, 100);
    p1_atk_active = 2'b10;
    tick();
    check("empty_box", 32'(p2_hit), 0);
    check("empty_box_hs", 32'(hitstop), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
